// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    // Fetch controller states.
    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        FAULT = 3'd4
    } fetch_state_e;

    // Sequential PC step; also defines the alignment requirement of a fetch.
    localparam int unsigned PC_INCR = 4;

    // Width of the boot counter for a given number of boot cycles.
    function automatic int unsigned boot_cnt_width(input int unsigned boot_cycles);
        return int'($clog2(boot_cycles)) + 1;
    endfunction

endpackage

// File: rtl/instr_hold_reg.sv
// Holding register for the fetched instruction, its PC and the valid flag.
module instr_hold_reg #(
    parameter int unsigned DATA_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 load,
    input  logic                 clear,
    input  logic [DATA_SIZE-1:0] load_instr,
    input  logic [DATA_SIZE-1:0] load_pc,
    output logic                 instr_valid,
    output logic [DATA_SIZE-1:0] instr,
    output logic [DATA_SIZE-1:0] instr_pc
);

    // Capture on load, drop valid on clear; data stays put until the next load.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else if (load) begin
            instr_valid <= 1'b1;
            instr       <= load_instr;
            instr_pc    <= load_pc;
        end else if (clear) begin
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch controller: issues a fetch at pc, waits for the response,
// hands the instruction to decode and pulses the PC update on acceptance.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned DATA_SIZE   = 32,
    parameter int unsigned BOOT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic [DATA_SIZE-1:0] pc,
    output logic                 pc_load,
    output logic                 pc_src,
    output logic                 imem_req,
    output logic [DATA_SIZE-1:0] imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [DATA_SIZE-1:0] imem_rdata,
    output logic                 instr_valid,
    output logic [DATA_SIZE-1:0] instr,
    output logic [DATA_SIZE-1:0] instr_pc,
    input  logic                 instr_ready,
    input  logic                 stall,
    input  logic                 redirect,
    output logic                 fault
);

    localparam int unsigned          CNT_W     = boot_cnt_width(BOOT_CYCLES);
    localparam logic [CNT_W-1:0]     BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);
    localparam logic [DATA_SIZE-1:0] ALIGN_MSK = DATA_SIZE'(PC_INCR - 1);

    fetch_state_e     state_q;
    fetch_state_e     state_d;
    logic [CNT_W-1:0] boot_cnt_q;
    logic [CNT_W-1:0] boot_cnt_d;
    logic             hold_load;
    logic             hold_clear;
    logic             misaligned_c;
    logic             accept_c;

    assign imem_addr    = pc;
    assign misaligned_c = (pc & ALIGN_MSK) != '0;
    assign accept_c     = instr_ready & ~stall;

    // State and boot counter registers.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q    <= BOOT;
            boot_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
        end
    end

    // Next state, boot counting, memory request and PC-update decode.
    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        imem_req   = 1'b0;
        pc_load    = 1'b0;
        pc_src     = 1'b0;
        hold_load  = 1'b0;
        hold_clear = 1'b0;
        fault      = 1'b0;

        case (state_q)
            BOOT: begin
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d = FETCH;
                end else begin
                    boot_cnt_d = boot_cnt_q + CNT_W'(1);
                end
            end

            FETCH: begin
                // A misaligned PC never reaches the memory port.
                if (misaligned_c) begin
                    state_d = FAULT;
                end else begin
                    imem_req = 1'b1;
                    if (imem_gnt) begin
                        state_d = WAIT;
                    end
                end
            end

            WAIT: begin
                if (imem_rvalid) begin
                    hold_load = 1'b1;
                    state_d   = HOLD;
                end
            end

            HOLD: begin
                // redirect only matters on the cycle decode actually takes the instruction.
                if (accept_c) begin
                    pc_load    = 1'b1;
                    pc_src     = redirect;
                    hold_clear = 1'b1;
                    state_d    = FETCH;
                end
            end

            FAULT: begin
                fault = 1'b1;
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Instruction, PC-of-instruction and valid storage.
    instr_hold_reg #(
        .DATA_SIZE (DATA_SIZE)
    ) u_instr_hold_reg (
        .clk         (clk),
        .areset      (areset),
        .load        (hold_load),
        .clear       (hold_clear),
        .load_instr  (imem_rdata),
        .load_pc     (pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc)
    );

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle fetch controller that sequences the program counter and the instruction-memory port of the RV32I core. It issues a fetch at the current PC, waits for the memory response, and presents the instruction to decode with a valid/ready handshake. On decode acceptance it pulses the PC load and selects sequential (PC+4) or branch (PC+ImmExt) update. It sits between `program_counter`, the instruction memory and the decode stage.

## Interface
- DATA_SIZE, 32, address/instruction width
- BOOT_CYCLES, 2, idle cycles after reset release before the first fetch (≥1)
- clk  in  1  clock, rising edge
- areset  in  1  reset, asynchronous, active-low
- pc  in  DATA_SIZE  current PC from `program_counter`
- pc_load  out  1  PC update enable, one-cycle pulse
- pc_src  out  1  0 = PC+4, 1 = PC+ImmExt; meaningful only while pc_load=1
- imem_req  out  1  fetch request
- imem_addr  out  DATA_SIZE  fetch address, equal to pc
- imem_gnt  in  1  memory accepted the request
- imem_rvalid  in  1  response data valid
- imem_rdata  in  DATA_SIZE  response instruction
- instr_valid  out  1  instruction available to decode
- instr  out  DATA_SIZE  held instruction
- instr_pc  out  DATA_SIZE  PC of the held instruction
- instr_ready  in  1  decode accepts the instruction
- stall  in  1  hazard stall; blocks acceptance
- redirect  in  1  branch/jump taken for the held instruction
- fault  out  1  sticky misaligned-fetch flag

## Operation
- States: BOOT, FETCH, WAIT, HOLD, FAULT.
- BOOT: the counter runs from 0 to BOOT_CYCLES-1, then the FSM moves to FETCH. No outputs are asserted.
- FETCH:
  - If pc[1:0] != 0: go to FAULT. No request is issued.
  - Otherwise: imem_req=1, imem_addr=pc. On imem_gnt go to WAIT; without imem_gnt stay in FETCH with the request held stable.
- WAIT: imem_req=0. On imem_rvalid, register instr<=imem_rdata and instr_pc<=pc, set instr_valid<=1, and go to HOLD.
- HOLD: instr_valid=1. The instruction is accepted when accept = instr_ready & ~stall.
  - On accept: pc_load=1, pc_src=redirect, instr_valid<=0, go to FETCH.
  - Otherwise: hold; instr and instr_pc stay stable.
- FAULT: fault=1. The FSM stays in FAULT until reset; all other outputs are deasserted.
- pc_load and pc_src are combinational from the state and inputs. pc_load=0 in every state except HOLD with accept.
- redirect is sampled only on the accept cycle and ignored otherwise.
- imem_rvalid is ignored outside WAIT, including a same-cycle rvalid in FETCH.

## Timing
- Reset values: pc_load=0, pc_src=0, imem_req=0, imem_addr=pc (follows input), instr_valid=0, instr=0, instr_pc=0, fault=0; state BOOT with the counter at 0.
- First imem_req rises BOOT_CYCLES cycles after areset deasserts.
- Minimum throughput is 3 cycles per instruction: FETCH with gnt in the same cycle, WAIT with rvalid in the next cycle, HOLD with accept in the next cycle.
- The PC updates on the edge where pc_load=1, so the following FETCH cycle drives the new address.
- instr_valid rises on the edge after the rvalid cycle and falls on the edge after the accept cycle.
- stall=1 in HOLD holds the instruction indefinitely; it has no effect in other states.
- Reset mid-operation, in any state: immediate return to BOOT with all outputs at reset values. An outstanding memory response after reset is discarded because rvalid is ignored in BOOT.
- Simultaneous stall and redirect with instr_ready: no accept, no pc_load; redirect must be re-presented on the accept cycle.

## Structure
- Shared package `fetch_pkg`:
  - state enum (BOOT, FETCH, WAIT, HOLD, FAULT)
  - PC_INCR=4
  - the boot-counter width macro, $clog2(BOOT_CYCLES)+1
- Sub-module `instr_hold_reg`:
  - registers instr, instr_pc and instr_valid
  - load/clear controls
  - asynchronous active-low reset to 0
- The FSM, boot counter and pc_load/pc_src decode live in the top level.

## Test plan
- Reset released, gnt and rvalid immediate, decode always ready: imem_req first high 2 cycles after release with imem_addr=0; instr_valid every 3rd cycle; pc_load pulses with pc_src=0; instr_pc steps 0, 4, 8.
- imem_gnt delayed 3 cycles, then rvalid delayed 2: imem_req and imem_addr stay stable 4 cycles; instr captured exactly on rvalid; rvalid injected in FETCH is ignored.
- HOLD with stall=1 for 5 cycles while instr_ready=1: no pc_load; instr and instr_pc stable; on stall release, exactly one pc_load.
- Accept with redirect=1 on instr_pc=0x10: pc_load=1 and pc_src=1; the next imem_addr is 0x10+ImmExt. A redirect pulse held during WAIT has no effect.
- pc forced to 0x6: FSM enters FAULT with no imem_req; fault=1 until areset low, after which BOOT restarts.
- areset asserted in WAIT, with rvalid arriving 1 cycle after release: all outputs 0; the response is discarded; a normal fetch at 0 follows.
